mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory/write-back stage directly downstream of the execution block of the 8-bit processor.
//  - Consumes ans_ex (ALU result or effective address), DM_data (store data) and flag_ex.
//  - Owns the byte-wide data memory.
//  - Registers the write-back result, destination register and status flags for the register file.
//  - Applies back-pressure to the execution stage while a load completes.
// PARAMETERS
//  DM_AW      8   data-memory address bits; depth = 2**DM_AW bytes (1..8)
//  RD_W       3   destination register index width (8 registers)
// PORTS
//  clk        in   1      single clock; all state changes on the rising edge
//  reset      in   1      synchronous, active-high
//  ex_valid   in   1      execution-stage outputs below are valid this cycle
//  ex_ready   out  1      stage can accept; transfer = ex_valid & ex_ready
//  ans_ex     in   8      ALU result / memory address
//  DM_data    in   8      store data
//  flag_ex    in   4      {Z,C,N,V} from execution stage
//  mem_op     in   2      00 none, 01 load, 10 store, 11 reserved (treated as none)
//  rd_ex      in   RD_W   destination register
//  we_ex      in   1      instruction writes a register
//  wb_en      out  1      one-cycle write strobe to register file
//  wb_rd      out  RD_W   write-back register index
//  wb_data    out  8      write-back value
//  flag_reg   out  4      architectural flag register
//  dm_err     out  1      sticky out-of-range access flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: one clk edge with reset=1.
//  - Resulting state: ACCEPT, wb_en=0, wb_rd=0, wb_data=00, flag_reg=0000, dm_err=0, ex_ready=1.
//  - Data memory contents are NOT cleared.
//  Memory: synchronous write and synchronous read (1-cycle read latency).
//  - Address = ans_ex[DM_AW-1:0]; upper bits ignored, so addresses wrap.
//  FSM, 2 states:
//  ACCEPT (ex_ready=1)
//   - transfer, mem_op=none:
//     - wb_data<=ans_ex, wb_rd<=rd_ex, wb_en<=we_ex, flag_reg<=flag_ex.
//     - Result is visible the cycle after transfer (latency 1). Stay in ACCEPT.
//   - transfer, store:
//     - mem[addr]<=DM_data at the transfer edge; wb_en<=0; flag_reg unchanged. Stay in ACCEPT.
//   - transfer, load:
//     - Issue RAM read, latch rd_ex and we_ex; wb_en<=0; go to LOAD_WAIT.
//   - no transfer: wb_en<=0. wb_data, wb_rd and flag_reg hold.
//  LOAD_WAIT (ex_ready=0)
//   - Next edge: wb_data<=RAM read data, wb_rd<=latched rd, wb_en<=latched we.
//   - flag_reg unchanged; return to ACCEPT.
//   - Load latency is 2 cycles from transfer to wb_en.
//   - ex_valid is ignored while in this state; upstream must hold its outputs.
//  wb_en is high for exactly one cycle per accepted register-writing instruction.
//  Back-to-back store then load to the same address: the load returns the stored byte (the write lands first).
//  Reset asserted in LOAD_WAIT: the load is dropped, no wb_en pulse, state returns to ACCEPT.
//  Reset has priority over any transfer in the same cycle.
// CONFIGURATION
//  DM_BOUND_CHECK_EN
//  - Defined:
//    - Any access with ans_ex >= 2**DM_AW is out of range.
//    - Out-of-range store: dropped, memory unchanged.
//    - Out-of-range load: returns 00 (still takes 2 cycles).
//    - dm_err set to 1 and held until reset.
//  - Undefined:
//    - Addresses wrap modulo 2**DM_AW.
//    - dm_err is tied to 0.
//  - With DM_AW=8 the two builds behave identically.
// TESTING
//  1 Reset:
//    - Hold reset 2 cycles with ex_valid=1, we_ex=1.
//    - Required: wb_en=0, flag_reg=0000, wb_data=00, ex_ready=1.
//  2 ALU pass-through:
//    - ans_ex=8'h80, rd_ex=3, we_ex=1, flag_ex=4'b1010, mem_op=00.
//    - Required next cycle: wb_en=1, wb_rd=3, wb_data=80, flag_reg=1010.
//    - Following cycle: wb_en=0.
//  3 Store then load:
//    - Store DM_data=8'h5A to ans_ex=8'h10, then immediately load 8'h10 with rd=5.
//    - Required: ex_ready=0 for 1 cycle, then wb_en=1, wb_rd=5, wb_data=5A.
//    - flag_reg unchanged throughout.
//  4 Reset mid-load:
//    - Load 8'h10, assert reset in the LOAD_WAIT cycle.
//    - Required: no wb_en pulse, ex_ready=1 after reset.
//    - Re-load of 8'h10 still returns 5A (memory not cleared).
//  5 Stall hold:
//    - Issue load followed by an ALU op (ans_ex=8'h22, rd=1) held valid.
//    - Required: ALU op accepted only after LOAD_WAIT.
//    - Order: load result first, then 22 to r1 on the next cycle.
//  6 Bounds (DM_AW=4):
//    - Store 8'h77 to 8'h13, then load 8'h03.
//    - Without DM_BOUND_CHECK_EN: load returns 77, dm_err=0.
//    - With DM_BOUND_CHECK_EN: store dropped, dm_err=1, load of 8'h13 returns 00.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory / write-back stage of the 8-bit processor.
// Owns the byte-wide data memory (sync write, 1-cycle sync read), registers
// the write-back result and the architectural flag register, and stalls the
// execution stage for one cycle while a load's read data comes back.
//
// Optional build macro: DM_BOUND_CHECK_EN
//   defined   - accesses with ans_ex >= 2**DM_AW are out of range: stores are
//               dropped, loads return 8'h00, and dm_err is set until reset.
//   undefined - addresses wrap modulo 2**DM_AW and dm_err is tied to 0.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ACCEPT     | ex_ready=1; ALU results and stores retire in one cycle
// LOAD_WAIT  | ex_ready=0; RAM read data returns and is written back

module mem_wb_stage #(
  parameter int DM_AW = 8,
  parameter int RD_W  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [7:0]      ans_ex,
  input  logic [7:0]      DM_data,
  input  logic [3:0]      flag_ex,
  input  logic [1:0]      mem_op,
  input  logic [RD_W-1:0] rd_ex,
  input  logic            we_ex,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_rd,
  output logic [7:0]      wb_data,
  output logic [3:0]      flag_reg,
  output logic            dm_err
);

  localparam logic [0:0] S_ACCEPT    = 1'b0;
  localparam logic [0:0] S_LOAD_WAIT = 1'b1;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam int DM_DEPTH = 1 << DM_AW;

  logic [7:0]      r_mem [0:DM_DEPTH-1];
  logic [0:0]      r_state;
  logic [RD_W-1:0] r_ld_rd;
  logic            r_ld_we;
  logic [7:0]      r_rd_data;
  logic [RD_W-1:0] r_wb_rd;
  logic [7:0]      r_wb_data;
  logic [3:0]      r_flag;
  logic            r_wb_en;

  logic             w_xfer;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_oob;
  logic             w_mem_we;
  logic [DM_AW-1:0] w_addr;

  assign w_xfer     = ex_valid & (r_state == S_ACCEPT);
  assign w_is_load  = (mem_op == OP_LOAD);
  assign w_is_store = (mem_op == OP_STORE);
  assign w_addr     = ans_ex[DM_AW-1:0];

`ifdef DM_BOUND_CHECK_EN
  logic [8:0] w_ans_ext;
  logic       r_dm_err;

  // Anything with bits set at or above DM_AW lies outside the memory.
  assign w_ans_ext = {1'b0, ans_ex};
  assign w_oob     = ((w_ans_ext >> DM_AW) != 9'd0);

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)
      r_dm_err <= 1'b0;
    else if (w_xfer & (w_is_load | w_is_store) & w_oob)
      r_dm_err <= 1'b1;
  end

  assign dm_err = r_dm_err;
`else
  assign w_oob  = 1'b0;
  assign dm_err = 1'b0;
`endif

  // Reset wins over a store presented in the same cycle.
  assign w_mem_we = w_xfer & w_is_store & ~w_oob & ~reset;

  // Data memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[w_addr] <= DM_data;
  end

  // Synchronous read issued at the load transfer edge; a store on the
  // previous edge has already landed, so store->load forwarding is free.
  always_ff @(posedge clk) begin
    if (w_xfer & w_is_load)
      r_rd_data <= w_oob ? 8'h00 : r_mem[w_addr];
  end

  // Stage FSM and write-back / flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_ACCEPT;
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= 8'h00;
      r_flag    <= 4'b0000;
      r_ld_rd   <= '0;
      r_ld_we   <= 1'b0;
    end else begin
      case (r_state)
        S_ACCEPT: begin
          r_wb_en <= 1'b0;
          if (ex_valid) begin
            if (w_is_load) begin
              r_ld_rd <= rd_ex;
              r_ld_we <= we_ex;
              r_state <= S_LOAD_WAIT;
            end else if (!w_is_store) begin
              // mem_op none or reserved: plain ALU result
              r_wb_data <= ans_ex;
              r_wb_rd   <= rd_ex;
              r_wb_en   <= we_ex;
              r_flag    <= flag_ex;
            end
          end
        end
        S_LOAD_WAIT: begin
          r_wb_data <= r_rd_data;
          r_wb_rd   <= r_ld_rd;
          r_wb_en   <= r_ld_we;
          r_state   <= S_ACCEPT;
        end
        default: begin
          r_wb_en <= 1'b0;
          r_state <= S_ACCEPT;
        end
      endcase
    end
  end

  assign ex_ready = (r_state == S_ACCEPT);
  assign wb_en    = r_wb_en;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign flag_reg = r_flag;

endmodule
